// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the incoming beat, with the
// decoded bundle buffered in a small FIFO and valid/ready handshakes on both sides.
module decode_stage #(
    parameter int PC_W     = 9,
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 0,
    parameter int DROP_NOP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            ALUsrc,
    output logic            Branch,
    output logic [31:0]     immediate,
    output logic [3:0]      ALUOp,
    output logic [1:0]      FUtype,
    output logic            Memread,
    output logic            Memwrite,
    output logic            Regwrite,
    output logic            illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_LUI  = 4'd8;
    localparam logic [3:0] ALU_AUI  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            alusrc;
        logic            branch;
        logic [31:0]     imm;
        logic [3:0]      aluop;
        logic [1:0]      futype;
        logic            memread;
        logic            memwrite;
        logic            regwrite;
        logic            illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'b000:  alu_sel = sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = sra ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    bundle_t dec;

    always_comb begin
        dec    = '0;
        dec.pc = i_pc;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec.rs1      = instruction[19:15];
                        dec.rs2      = instruction[24:20];
                        dec.rd       = instruction[11:7];
                        dec.futype   = 2'b11;
                        dec.aluop    = {1'b0, funct3};
                        dec.regwrite = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    dec.rs1      = instruction[19:15];
                    dec.rs2      = instruction[24:20];
                    dec.rd       = instruction[11:7];
                    dec.regwrite = 1'b1;
                    dec.aluop    = alu_sel(funct3, funct7 == 7'b0100000, funct7[5]);
                end
            end
            OPC_OPIMM: begin
                dec.rs1      = instruction[19:15];
                dec.rd       = instruction[11:7];
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
                dec.aluop    = alu_sel(funct3, 1'b0, funct7[5]);
            end
            OPC_LOAD: begin
                dec.rs1      = instruction[19:15];
                dec.rd       = instruction[11:7];
                dec.alusrc   = 1'b1;
                dec.futype   = 2'b10;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
                dec.aluop    = {1'b0, funct3};
            end
            OPC_STORE: begin
                dec.rs1      = instruction[19:15];
                dec.rs2      = instruction[24:20];
                dec.alusrc   = 1'b1;
                dec.futype   = 2'b10;
                dec.memwrite = 1'b1;
                dec.imm      = imm_s;
                dec.aluop    = {1'b0, funct3};
            end
            OPC_BRANCH: begin
                dec.rs1    = instruction[19:15];
                dec.rs2    = instruction[24:20];
                dec.branch = 1'b1;
                dec.futype = 2'b01;
                dec.imm    = imm_b;
                dec.aluop  = {1'b0, funct3};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.rd       = instruction[11:7];
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = imm_u;
                dec.aluop    = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUI;
            end
            OPC_JAL: begin
                dec.rd       = instruction[11:7];
                dec.alusrc   = 1'b1;
                dec.branch   = 1'b1;
                dec.regwrite = 1'b1;
                dec.futype   = 2'b01;
                dec.imm      = imm_j;
                dec.aluop    = ALU_LUI;
            end
            OPC_JALR: begin
                dec.rs1      = instruction[19:15];
                dec.rd       = instruction[11:7];
                dec.alusrc   = 1'b1;
                dec.branch   = 1'b1;
                dec.regwrite = 1'b1;
                dec.futype   = 2'b01;
                dec.imm      = imm_i;
                dec.aluop    = ALU_AUI;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; stop them before rename.
        if (dec.rd == 5'd0) dec.regwrite = 1'b0;
    end

    bundle_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           is_nop, push, pop;

    assign o_ready = (count < CW'(DEPTH));
    assign o_valid = (count != '0);
    assign is_nop  = (DROP_NOP != 0) && (instruction == 32'h0000_0013);
    assign push    = i_valid && o_ready && !flush && !is_nop;
    assign pop     = o_valid && i_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    bundle_t head;
    assign head = o_valid ? mem[rd_ptr] : '0;

    assign o_pc      = head.pc;
    assign rs1       = head.rs1;
    assign rs2       = head.rs2;
    assign rd        = head.rd;
    assign ALUsrc    = head.alusrc;
    assign Branch    = head.branch;
    assign immediate = head.imm;
    assign ALUOp     = head.aluop;
    assign FUtype    = head.futype;
    assign Memread   = head.memread;
    assign Memwrite  = head.memwrite;
    assign Regwrite  = head.regwrite;
    assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (M enabled / disabled) share the
// stimulus; expected bundles are queued at accept time and compared at the head.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, i_valid, i_ready;
    logic [31:0] instruction;
    logic [8:0]  i_pc;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic        branch;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic [1:0]  fu;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        ill;
    } bundle_t;

    logic        o_ready_m, o_valid_m, o_ready_b, o_valid_b;
    logic [8:0]  o_pc_m, o_pc_b;
    logic [4:0]  rs1_m, rs2_m, rd_m, rs1_b, rs2_b, rd_b;
    logic        alusrc_m, branch_m, mr_m, mw_m, rw_m, ill_m;
    logic        alusrc_b, branch_b, mr_b, mw_b, rw_b, ill_b;
    logic [31:0] imm_m, imm_b;
    logic [3:0]  aluop_m, aluop_b;
    logic [1:0]  fu_m, fu_b;

    decode_stage #(.PC_W(9), .DEPTH(2), .ENABLE_M(1), .DROP_NOP(1)) dut_m (
        .clk(clk), .reset(reset), .flush(flush), .instruction(instruction), .i_pc(i_pc),
        .i_valid(i_valid), .o_ready(o_ready_m), .o_valid(o_valid_m), .i_ready(i_ready),
        .o_pc(o_pc_m), .rs1(rs1_m), .rs2(rs2_m), .rd(rd_m), .ALUsrc(alusrc_m),
        .Branch(branch_m), .immediate(imm_m), .ALUOp(aluop_m), .FUtype(fu_m),
        .Memread(mr_m), .Memwrite(mw_m), .Regwrite(rw_m), .illegal(ill_m)
    );

    decode_stage #(.PC_W(9), .DEPTH(2), .ENABLE_M(0), .DROP_NOP(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .instruction(instruction), .i_pc(i_pc),
        .i_valid(i_valid), .o_ready(o_ready_b), .o_valid(o_valid_b), .i_ready(i_ready),
        .o_pc(o_pc_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .ALUsrc(alusrc_b),
        .Branch(branch_b), .immediate(imm_b), .ALUOp(aluop_b), .FUtype(fu_b),
        .Memread(mr_b), .Memwrite(mw_b), .Regwrite(rw_b), .illegal(ill_b)
    );

    bundle_t obs_m, obs_b;
    assign obs_m = {o_pc_m, rs1_m, rs2_m, rd_m, alusrc_m, branch_m, imm_m, aluop_m, fu_m,
                    mr_m, mw_m, rw_m, ill_m};
    assign obs_b = {o_pc_b, rs1_b, rs2_b, rd_b, alusrc_b, branch_b, imm_b, aluop_b, fu_b,
                    mr_b, mw_b, rw_b, ill_b};

    int      n_cmp = 0;
    int      n_err = 0;
    bundle_t q_m[$];
    bundle_t q_b[$];

    task automatic chk(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic bundle_t mk(input logic [8:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [4:0] d, input logic asrc, input logic br,
                                   input logic [31:0] imm, input logic [3:0] op, input logic [1:0] fu,
                                   input logic mr, input logic mw, input logic rw, input logic ill);
        mk = {pc, s1, s2, d, asrc, br, imm, op, fu, mr, mw, rw, ill};
    endfunction

    // Head checker: occupancy flags against the model queue, head fields on each pop.
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid_m", 96'(o_valid_m), 96'(q_m.size() != 0));
            chk("ready_m", 96'(o_ready_m), 96'(q_m.size() < 2));
            chk("valid_b", 96'(o_valid_b), 96'(q_b.size() != 0));
            chk("ready_b", 96'(o_ready_b), 96'(q_b.size() < 2));
            if (!o_valid_m) chk("idle_m", 96'(obs_m), 96'd0);
            else if (i_ready && !flush && q_m.size() != 0) chk("head_m", 96'(obs_m), 96'(q_m.pop_front()));
            if (!o_valid_b) chk("idle_b", 96'(obs_b), 96'd0);
            else if (i_ready && !flush && q_b.size() != 0) chk("head_b", 96'(obs_b), 96'(q_b.pop_front()));
        end
    end

    task automatic beat(input logic [31:0] ins, input logic [8:0] pc,
                        input bundle_t e_m, input bundle_t e_b, input bit enq);
        int  waited = 0;
        bit  ok;
        instruction = ins;
        i_pc        = pc;
        i_valid     = 1'b1;
        @(negedge clk);
        while (!o_ready_m && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = o_ready_m;
        if (!ok) chk("accept_timeout", 96'(o_ready_m), 96'd1);
        @(posedge clk);
        if (ok && enq) begin
            q_m.push_back(e_m);
            q_b.push_back(e_b);
        end
        #1 i_valid = 1'b0;
    endtask

    task automatic beat1(input logic [31:0] ins, input bundle_t e);
        beat(ins, e.pc, e, e, 1'b1);
    endtask

    task automatic flush_beat(input logic [31:0] ins);
        instruction = ins;
        i_pc        = 9'h1FF;
        i_valid     = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        q_m.delete();
        q_b.delete();
        #1;
        flush   = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        instruction = 32'h0; i_pc = 9'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // basic ADD, one-cycle latency
        beat1(32'h002081B3, mk(9'h10, 5'd1, 5'd2, 5'd3, 0, 0, 32'h0, 4'd0, 2'b00, 0, 0, 1, 0));
        repeat (2) @(posedge clk); #1;

        // backpressure: fill, third beat stalls until downstream opens
        i_ready = 1'b0;
        beat1(32'h40628233, mk(9'h14, 5'd5, 5'd6, 5'd4, 0, 0, 32'h0, 4'd1,  2'b00, 0, 0, 1, 0));
        beat1(32'h409453B3, mk(9'h18, 5'd8, 5'd9, 5'd7, 0, 0, 32'h0, 4'd10, 2'b00, 0, 0, 1, 0));
        fork
            beat1(32'h00C5B533, mk(9'h1C, 5'd11, 5'd12, 5'd10, 0, 0, 32'h0, 4'd11, 2'b00, 0, 0, 1, 0));
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // NOP dropped, ADDI with negative immediate
        beat(32'h00000013, 9'h20, '0, '0, 1'b0);
        beat1(32'hFFF00093, mk(9'h24, 5'd0, 5'd0, 5'd1, 1, 0, 32'hFFFFFFFF, 4'd0, 2'b00, 0, 0, 1, 0));
        repeat (2) @(posedge clk); #1;

        // flush when full, then flush at one entry with an acceptable beat
        i_ready = 1'b0;
        beat1(32'h0080A103, mk(9'h30, 5'd1, 5'd0, 5'd2, 1, 0, 32'd8,  4'd2, 2'b10, 1, 0, 1, 0));
        beat1(32'h00322623, mk(9'h34, 5'd4, 5'd3, 5'd0, 1, 0, 32'd12, 4'd2, 2'b10, 0, 1, 0, 0));
        flush_beat(32'h002081B3);
        repeat (2) @(posedge clk); #1;
        beat1(32'h0080A103, mk(9'h38, 5'd1, 5'd0, 5'd2, 1, 0, 32'd8, 4'd2, 2'b10, 1, 0, 1, 0));
        flush_beat(32'h002081B3);
        i_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // streaming mix with push+pop at count 1
        beat1(32'h0080A103, mk(9'h3C, 5'd1, 5'd0, 5'd2, 1, 0, 32'd8,  4'd2, 2'b10, 1, 0, 1, 0));
        beat1(32'h00322623, mk(9'h3E, 5'd4, 5'd3, 5'd0, 1, 0, 32'd12, 4'd2, 2'b10, 0, 1, 0, 0));
        beat(32'h027302B3, 9'h40,
             mk(9'h40, 5'd6, 5'd7, 5'd5, 0, 0, 32'h0, 4'd0, 2'b11, 0, 0, 1, 0),
             mk(9'h40, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0, 4'd0, 2'b00, 0, 0, 0, 1), 1'b1);
        beat(32'h027352B3, 9'h42,
             mk(9'h42, 5'd6, 5'd7, 5'd5, 0, 0, 32'h0, 4'd5, 2'b11, 0, 0, 1, 0),
             mk(9'h42, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0, 4'd0, 2'b00, 0, 0, 0, 1), 1'b1);
        beat1(32'hFE000EE3, mk(9'h44, 5'd0, 5'd0, 5'd0, 0, 1, 32'hFFFFFFFC, 4'd0,  2'b01, 0, 0, 0, 0));
        beat1(32'h00508013, mk(9'h48, 5'd1, 5'd0, 5'd0, 1, 0, 32'd5,        4'd0,  2'b00, 0, 0, 0, 0));
        beat1(32'h123452B7, mk(9'h4C, 5'd0, 5'd0, 5'd5, 1, 0, 32'h12345000, 4'd8,  2'b00, 0, 0, 1, 0));
        beat1(32'h00001197, mk(9'h50, 5'd0, 5'd0, 5'd3, 1, 0, 32'h00001000, 4'd9,  2'b00, 0, 0, 1, 0));
        beat1(32'hFF9FF0EF, mk(9'h54, 5'd0, 5'd0, 5'd1, 1, 1, 32'hFFFFFFF8, 4'd8,  2'b01, 0, 0, 1, 0));
        beat1(32'h004100E7, mk(9'h58, 5'd2, 5'd0, 5'd1, 1, 1, 32'd4,        4'd9,  2'b01, 0, 0, 1, 0));
        beat1(32'h40315093, mk(9'h5C, 5'd2, 5'd0, 5'd1, 1, 0, 32'h00000403, 4'd10, 2'b00, 0, 0, 1, 0));
        beat1(32'hFFFFFFFF, mk(9'h60, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0,        4'd0,  2'b00, 0, 0, 0, 1));

        for (int i = 0; i < 100 && (q_m.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk); #1;
        chk("drain_m", 96'(q_m.size()), 96'd0);
        chk("drain_b", 96'(q_b.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
